// File: rtl/stack_engine.sv
// Stack sequencer for the memory stage: expands PUSH/POP/CALL/RET/INT/RTI
// into per-word memory transfers, tracks sp and rejects frames that would not fit.
module stack_engine #(
    parameter int               DATA_W  = 16,
    parameter int               ADDR_W  = 16,
    parameter int               PC_W    = 32,
    parameter int               FLAG_W  = 4,
    parameter logic [ADDR_W-1:0] SP_INIT = '1,
    parameter logic [ADDR_W-1:0] SP_MIN  = '0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_op_valid,
    input  logic [2:0]        i_op,
    output logic              o_op_ready,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic [PC_W-1:0]   i_pc_in,
    input  logic [FLAG_W-1:0] i_flags_in,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic              o_mem_we,
    output logic              o_mem_re,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic [ADDR_W-1:0] o_sp,
    output logic              o_done,
    output logic              o_err,
    output logic [1:0]        o_err_code,
    output logic [DATA_W-1:0] o_pop_data,
    output logic [PC_W-1:0]   o_pc_out,
    output logic [FLAG_W-1:0] o_flags_out
);

    localparam int PC_WORDS = PC_W / DATA_W;
    localparam int FRAME_W  = (PC_WORDS + 1) * DATA_W;
    localparam int CNT_W    = $clog2(PC_WORDS + 2);

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_PUSH = 3'b001;
    localparam logic [2:0] OP_POP  = 3'b010;
    localparam logic [2:0] OP_CALL = 3'b011;
    localparam logic [2:0] OP_RET  = 3'b100;
    localparam logic [2:0] OP_INT  = 3'b101;
    localparam logic [2:0] OP_RTI  = 3'b110;
    localparam logic [2:0] OP_ILL  = 3'b111;

    typedef enum logic {S_IDLE, S_XFER} state_t;

    state_t             r_state;
    state_t             w_nextState;
    logic [ADDR_W-1:0]  r_sp;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_isPush;
    logic               r_first;
    logic [2:0]         r_op;
    logic [FRAME_W-1:0] r_frame;
    logic [PC_W-1:0]    r_pcAcc;
    logic [FLAG_W-1:0]  r_flagsAcc;
    logic               r_done;
    logic               r_err;
    logic [1:0]         r_errCode;
    logic [DATA_W-1:0]  r_popData;
    logic [PC_W-1:0]    r_pcOut;
    logic [FLAG_W-1:0]  r_flagsOut;

    logic               w_start;
    logic               w_reject;
    logic [1:0]         w_errCode;
    logic [CNT_W-1:0]   w_k;
    logic               w_isPush;
    logic               w_isPop;
    logic [ADDR_W:0]    w_free;
    logic [ADDR_W:0]    w_used;
    logic [FRAME_W-1:0] w_frame;
    logic               w_lastWord;

    assign w_free = (r_sp < SP_MIN) ? '0 : ({1'b0, r_sp} - {1'b0, SP_MIN} + (ADDR_W+1)'(1));
    assign w_used = (r_sp > SP_INIT) ? '0 : ({1'b0, SP_INIT} - {1'b0, r_sp});
    assign w_lastWord = (r_state == S_XFER) && (r_cnt == CNT_W'(1));

    always_comb begin
        w_nextState = r_state;
        w_start     = 1'b0;
        w_reject    = 1'b0;
        w_errCode   = 2'b00;
        w_k         = '0;
        w_isPush    = 1'b0;
        w_isPop     = 1'b0;
        w_frame     = '0;
        case (i_op)
            OP_PUSH: begin w_k = CNT_W'(1);            w_isPush = 1'b1; w_frame = FRAME_W'(i_push_data); end
            OP_POP:  begin w_k = CNT_W'(1);            w_isPop  = 1'b1; end
            OP_CALL: begin w_k = CNT_W'(PC_WORDS);     w_isPush = 1'b1; w_frame = FRAME_W'(i_pc_in); end
            OP_RET:  begin w_k = CNT_W'(PC_WORDS);     w_isPop  = 1'b1; end
            OP_INT:  begin w_k = CNT_W'(PC_WORDS + 1); w_isPush = 1'b1; w_frame = {DATA_W'(i_flags_in), i_pc_in}; end
            OP_RTI:  begin w_k = CNT_W'(PC_WORDS + 1); w_isPop  = 1'b1; end
            default: ;
        endcase
        case (r_state)
            S_IDLE: begin
                if (i_op_valid) begin
                    if (i_op == OP_ILL) begin
                        w_reject  = 1'b1;
                        w_errCode = 2'b11;
                    end else if (w_isPush && (w_free < (ADDR_W+1)'(w_k))) begin
                        w_reject  = 1'b1;
                        w_errCode = 2'b01;
                    end else if (w_isPop && (w_used < (ADDR_W+1)'(w_k))) begin
                        w_reject  = 1'b1;
                        w_errCode = 2'b10;
                    end else if (i_op != OP_NOP) begin
                        w_start     = 1'b1;
                        w_nextState = S_XFER;
                    end
                end
            end
            S_XFER: begin
                if (w_lastWord) w_nextState = S_IDLE;
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_nextState;
    end

    // Frame words shift out LSW-first on push; popped words shift into the PC accumulator.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sp       <= SP_INIT;
            r_cnt      <= '0;
            r_isPush   <= 1'b0;
            r_first    <= 1'b0;
            r_op       <= OP_NOP;
            r_frame    <= '0;
            r_pcAcc    <= '0;
            r_flagsAcc <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_errCode  <= 2'b00;
            r_popData  <= '0;
            r_pcOut    <= '0;
            r_flagsOut <= '0;
        end else begin
            r_done <= w_lastWord;
            r_err  <= w_reject;
            if (w_reject) r_errCode <= w_errCode;
            if (w_start) begin
                r_cnt    <= w_k;
                r_isPush <= w_isPush;
                r_first  <= 1'b1;
                r_op     <= i_op;
                r_frame  <= w_frame;
                r_pcAcc  <= '0;
            end else if (r_state == S_XFER) begin
                r_cnt   <= r_cnt - CNT_W'(1);
                r_first <= 1'b0;
                if (r_isPush) begin
                    r_frame <= r_frame >> DATA_W;
                    r_sp    <= r_sp - ADDR_W'(1);
                end else begin
                    r_sp <= r_sp + ADDR_W'(1);
                    if (r_op == OP_RTI && r_first) r_flagsAcc <= i_mem_rdata[FLAG_W-1:0];
                    else                           r_pcAcc    <= PC_W'({r_pcAcc, i_mem_rdata});
                    if (w_lastWord) begin
                        case (r_op)
                            OP_POP: r_popData <= i_mem_rdata;
                            OP_RET: r_pcOut   <= PC_W'({r_pcAcc, i_mem_rdata});
                            OP_RTI: begin
                                r_pcOut    <= PC_W'({r_pcAcc, i_mem_rdata});
                                r_flagsOut <= r_flagsAcc;
                            end
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

    assign o_op_ready  = (r_state == S_IDLE);
    assign o_mem_we    = (r_state == S_XFER) && r_isPush;
    assign o_mem_re    = (r_state == S_XFER) && !r_isPush;
    assign o_mem_addr  = o_mem_re ? (r_sp + ADDR_W'(1)) : r_sp;
    assign o_mem_wdata = o_mem_we ? r_frame[DATA_W-1:0] : '0;
    assign o_sp        = r_sp;
    assign o_done      = r_done;
    assign o_err       = r_err;
    assign o_err_code  = r_errCode;
    assign o_pop_data  = r_popData;
    assign o_pc_out    = r_pcOut;
    assign o_flags_out = r_flagsOut;

endmodule

// File: tb/tb_stack_engine.sv
// Directed bench for stack_engine with a 16-word memory model covering FFF0..FFFF.
module tb_stack_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        op_valid;
    logic [2:0]  op;
    logic        op_ready;
    logic [15:0] push_data;
    logic [31:0] pc_in;
    logic [3:0]  flags_in;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [15:0] mem_rdata;
    logic [15:0] sp;
    logic        done;
    logic        err;
    logic [1:0]  err_code;
    logic [15:0] pop_data;
    logic [31:0] pc_out;
    logic [3:0]  flags_out;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem [0:15];

    stack_engine #(
        .DATA_W(16), .ADDR_W(16), .PC_W(32), .FLAG_W(4),
        .SP_INIT(16'hFFFF), .SP_MIN(16'hFFF0)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_op_valid(op_valid), .i_op(op),
        .o_op_ready(op_ready), .i_push_data(push_data), .i_pc_in(pc_in),
        .i_flags_in(flags_in), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
        .o_mem_we(mem_we), .o_mem_re(mem_re), .i_mem_rdata(mem_rdata), .o_sp(sp),
        .o_done(done), .o_err(err), .o_err_code(err_code), .o_pop_data(pop_data),
        .o_pc_out(pc_out), .o_flags_out(flags_out)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[3:0]];
    always @(posedge clk) if (mem_we) mem[mem_addr[3:0]] <= mem_wdata;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic applyStimulus(input logic v, input logic [2:0] o, input logic [15:0] d,
                                 input logic [31:0] pc, input logic [3:0] f);
        op_valid  = v;
        op        = o;
        push_data = d;
        pc_in     = pc;
        flags_in  = f;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
        rst_n = 1'b0;
        applyStimulus(0, 3'b000, 16'h0, 32'h0, 4'h0);
        cyc(); cyc();
        rst_n = 1'b1;
        cyc();

        // Reset state
        checkOutput("rst_sp", sp, 16'hFFFF);
        checkOutput("rst_ready", op_ready, 1'b1);
        checkOutput("rst_we", mem_we, 1'b0);
        checkOutput("rst_re", mem_re, 1'b0);
        checkOutput("rst_done", done, 1'b0);
        checkOutput("rst_err", err, 1'b0);
        checkOutput("rst_errcode", err_code, 2'b00);
        checkOutput("rst_popdata", pop_data, 16'h0);
        checkOutput("rst_pcout", pc_out, 32'h0);
        checkOutput("rst_flagsout", flags_out, 4'h0);
        checkOutput("rst_wdata", mem_wdata, 16'h0);
        checkOutput("rst_addr", mem_addr, 16'hFFFF);

        // Underflow: POP on empty stack
        applyStimulus(1, 3'b010, 16'h0, 32'h0, 4'h0);
        cyc();
        applyStimulus(0, 3'b000, 16'h0, 32'h0, 4'h0);
        checkOutput("uf_err", err, 1'b1);
        checkOutput("uf_code", err_code, 2'b10);
        checkOutput("uf_re", mem_re, 1'b0);
        checkOutput("uf_sp", sp, 16'hFFFF);
        checkOutput("uf_ready", op_ready, 1'b1);
        cyc();
        checkOutput("uf_errpulse", err, 1'b0);
        checkOutput("uf_codeheld", err_code, 2'b10);

        // PUSH ABCD then POP
        applyStimulus(1, 3'b001, 16'hABCD, 32'h0, 4'h0);
        cyc();
        applyStimulus(0, 3'b000, 16'h0, 32'h0, 4'h0);
        checkOutput("push_we", mem_we, 1'b1);
        checkOutput("push_addr", mem_addr, 16'hFFFF);
        checkOutput("push_wdata", mem_wdata, 16'hABCD);
        checkOutput("push_ready", op_ready, 1'b0);
        cyc();
        checkOutput("push_done", done, 1'b1);
        checkOutput("push_sp", sp, 16'hFFFE);
        checkOutput("push_we_off", mem_we, 1'b0);
        applyStimulus(1, 3'b010, 16'h0, 32'h0, 4'h0);
        cyc();
        applyStimulus(0, 3'b000, 16'h0, 32'h0, 4'h0);
        checkOutput("pop_re", mem_re, 1'b1);
        checkOutput("pop_addr", mem_addr, 16'hFFFF);
        checkOutput("pop_we", mem_we, 1'b0);
        cyc();
        checkOutput("pop_done", done, 1'b1);
        checkOutput("pop_data", pop_data, 16'hABCD);
        checkOutput("pop_sp", sp, 16'hFFFF);

        // CALL then RET
        applyStimulus(1, 3'b011, 16'h0, 32'h0001_2345, 4'h0);
        cyc();
        applyStimulus(0, 3'b000, 16'h0, 32'h0, 4'h0);
        checkOutput("call_w1_addr", mem_addr, 16'hFFFF);
        checkOutput("call_w1_data", mem_wdata, 16'h2345);
        checkOutput("call_w1_we", mem_we, 1'b1);
        cyc();
        checkOutput("call_w2_addr", mem_addr, 16'hFFFE);
        checkOutput("call_w2_data", mem_wdata, 16'h0001);
        checkOutput("call_w2_done", done, 1'b0);
        cyc();
        checkOutput("call_done", done, 1'b1);
        checkOutput("call_sp", sp, 16'hFFFD);
        applyStimulus(1, 3'b100, 16'h0, 32'h0, 4'h0);
        cyc();
        applyStimulus(0, 3'b000, 16'h0, 32'h0, 4'h0);
        checkOutput("ret_r1_addr", mem_addr, 16'hFFFE);
        checkOutput("ret_r1_re", mem_re, 1'b1);
        cyc();
        checkOutput("ret_r2_addr", mem_addr, 16'hFFFF);
        cyc();
        checkOutput("ret_done", done, 1'b1);
        checkOutput("ret_pc", pc_out, 32'h0001_2345);
        checkOutput("ret_sp", sp, 16'hFFFF);
        checkOutput("ret_popheld", pop_data, 16'hABCD);

        // INT then RTI
        applyStimulus(1, 3'b101, 16'h0, 32'h0000_0042, 4'b1010);
        cyc();
        applyStimulus(0, 3'b000, 16'h0, 32'h0, 4'h0);
        checkOutput("int_w1", {mem_addr, mem_wdata}, 32'hFFFF_0042);
        cyc();
        checkOutput("int_w2", {mem_addr, mem_wdata}, 32'hFFFE_0000);
        cyc();
        checkOutput("int_w3", {mem_addr, mem_wdata}, 32'hFFFD_000A);
        checkOutput("int_w3_we", mem_we, 1'b1);
        cyc();
        checkOutput("int_done", done, 1'b1);
        checkOutput("int_sp", sp, 16'hFFFC);
        checkOutput("int_pcheld", pc_out, 32'h0001_2345);
        applyStimulus(1, 3'b110, 16'h0, 32'h0, 4'h0);
        cyc();
        applyStimulus(0, 3'b000, 16'h0, 32'h0, 4'h0);
        checkOutput("rti_r1_addr", mem_addr, 16'hFFFD);
        cyc(); cyc(); cyc();
        checkOutput("rti_done", done, 1'b1);
        checkOutput("rti_flags", flags_out, 4'b1010);
        checkOutput("rti_pc", pc_out, 32'h0000_0042);
        checkOutput("rti_sp", sp, 16'hFFFF);

        // Fill the 16-word stack, then overflow
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1, 3'b001, 16'h1000 + 16'(i), 32'h0, 4'h0);
            cyc();
            applyStimulus(0, 3'b000, 16'h0, 32'h0, 4'h0);
            cyc();
            checkOutput($sformatf("fill_done_%0d", i), done, 1'b1);
        end
        checkOutput("fill_sp", sp, 16'hFFEF);
        applyStimulus(1, 3'b001, 16'h9999, 32'h0, 4'h0);
        cyc();
        applyStimulus(0, 3'b000, 16'h0, 32'h0, 4'h0);
        checkOutput("of_err", err, 1'b1);
        checkOutput("of_code", err_code, 2'b01);
        checkOutput("of_we", mem_we, 1'b0);
        checkOutput("of_sp", sp, 16'hFFEF);
        applyStimulus(1, 3'b010, 16'h0, 32'h0, 4'h0);
        cyc();
        applyStimulus(0, 3'b000, 16'h0, 32'h0, 4'h0);
        cyc();
        checkOutput("of_pop_data", pop_data, 16'h100F);
        checkOutput("of_pop_sp", sp, 16'hFFF0);
        applyStimulus(1, 3'b011, 16'h0, 32'h1234_5678, 4'h0);
        cyc();
        applyStimulus(0, 3'b000, 16'h0, 32'h0, 4'h0);
        checkOutput("ofc_err", err, 1'b1);
        checkOutput("ofc_code", err_code, 2'b01);
        checkOutput("ofc_we", mem_we, 1'b0);
        checkOutput("ofc_sp", sp, 16'hFFF0);
        checkOutput("ofc_mem", mem[0], 16'h100F);

        // Reset in the middle of INT, after the first word is written
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();
        checkOutput("rst2_sp", sp, 16'hFFFF);
        applyStimulus(1, 3'b101, 16'h0, 32'h0000_0042, 4'b0101);
        cyc();
        applyStimulus(0, 3'b000, 16'h0, 32'h0, 4'h0);
        checkOutput("abort_w1_we", mem_we, 1'b1);
        cyc();
        checkOutput("abort_w2_we", mem_we, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("abort_we_drop", mem_we, 1'b0);
        checkOutput("abort_sp", sp, 16'hFFFF);
        cyc();
        rst_n = 1'b1;
        cyc();
        checkOutput("abort_ready", op_ready, 1'b1);
        checkOutput("abort_mem_f", mem[15], 16'h0042);
        checkOutput("abort_mem_e", mem[14], 16'h1001);
        checkOutput("abort_done", done, 1'b0);

        // op_valid held: PUSH, PUSH, illegal
        applyStimulus(1, 3'b001, 16'h1111, 32'h0, 4'h0);
        cyc();
        applyStimulus(1, 3'b001, 16'h2222, 32'h0, 4'h0);
        checkOutput("b2b_x1_ready", op_ready, 1'b0);
        checkOutput("b2b_x1_wdata", mem_wdata, 16'h1111);
        cyc();
        checkOutput("b2b_done1", done, 1'b1);
        checkOutput("b2b_ready1", op_ready, 1'b1);
        cyc();
        applyStimulus(1, 3'b111, 16'h0, 32'h0, 4'h0);
        checkOutput("b2b_x2_ready", op_ready, 1'b0);
        checkOutput("b2b_x2_wdata", mem_wdata, 16'h2222);
        checkOutput("b2b_x2_addr", mem_addr, 16'hFFFE);
        checkOutput("b2b_x2_done", done, 1'b0);
        cyc();
        checkOutput("b2b_done2", done, 1'b1);
        checkOutput("b2b_err_early", err, 1'b0);
        cyc();
        applyStimulus(0, 3'b000, 16'h0, 32'h0, 4'h0);
        checkOutput("b2b_err", err, 1'b1);
        checkOutput("b2b_code", err_code, 2'b11);
        checkOutput("b2b_done_off", done, 1'b0);
        checkOutput("b2b_sp", sp, 16'hFFFD);
        checkOutput("b2b_ready_err", op_ready, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
